// File: rtl/cordic_pipe_multi_if.sv
// Handshake bundle for the multi-mode CORDIC pipe: sample in, result out, with
// mode and user tag travelling alongside.
interface cordic_pipe_multi_if #(
    parameter int NUM_WIDTH = 24,
    parameter int TAG_WIDTH = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_mode;
    logic signed [NUM_WIDTH-1:0] in_x;
    logic signed [NUM_WIDTH-1:0] in_y;
    logic signed [NUM_WIDTH-1:0] in_z;
    logic [TAG_WIDTH-1:0]        in_tag;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [NUM_WIDTH-1:0] out_x;
    logic signed [NUM_WIDTH-1:0] out_y;
    logic signed [NUM_WIDTH-1:0] out_z;
    logic                        out_mode;
    logic [TAG_WIDTH-1:0]        out_tag;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z, out_mode, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z, out_mode, out_tag
    );
endinterface

// File: rtl/cordic_pipe_multi.sv
// Fully pipelined CORDIC, rotation or vectoring selected per sample, with a
// quadrant pre-rotation stage and a single global stall for backpressure.
module cordic_pipe_multi #(
    parameter int NUM_WIDTH = 24,
    parameter int FRAC_BITS = 20,
    parameter int STAGE_CNT = 20,
    parameter int TAG_WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    cordic_pipe_multi_if.slave io
);
    typedef logic signed [NUM_WIDTH-1:0] num_t;

    function automatic num_t to_fixed(input real r);
        real s;
        s = r * (2.0 ** FRAC_BITS);
        return num_t'($rtoi(s < 0.0 ? s - 0.5 : s + 0.5));
    endfunction

    // atan(2^-i) by its Taylor series; only evaluated at elaboration.
    function automatic real atan_pow2(input int i);
        real t, t2, term, acc;
        if (i == 0) return 0.78539816339744831;
        t    = 1.0 / (2.0 ** i);
        t2   = t * t;
        term = t;
        acc  = 0.0;
        for (int k = 0; k < 40; k++) begin
            acc  = acc + ((k % 2 == 0) ? term : -term) / real'(2 * k + 1);
            term = term * t2;
        end
        return acc;
    endfunction

    localparam num_t HALF_PI_C = to_fixed(1.57079632679489662);

    logic                 en;
    logic [STAGE_CNT:0]   vld_q;
    logic [STAGE_CNT:0]   mode_q;
    logic [TAG_WIDTH-1:0] tag_q [0:STAGE_CNT];
    num_t                 x_q   [0:STAGE_CNT];
    num_t                 y_q   [0:STAGE_CNT];
    num_t                 z_q   [0:STAGE_CNT];
    num_t                 x_d   [1:STAGE_CNT];
    num_t                 y_d   [1:STAGE_CNT];
    num_t                 z_d   [1:STAGE_CNT];
    num_t                 in_x, in_y, in_z;
    num_t                 pre_x_d, pre_y_d, pre_z_d;
    logic                 out_vld_q, out_mode_q;
    logic [TAG_WIDTH-1:0] out_tag_q;
    num_t                 out_x_q, out_y_q, out_z_q;

    assign en          = !out_vld_q || io.out_ready;
    assign io.in_ready = en;
    assign in_x        = num_t'(io.in_x);
    assign in_y        = num_t'(io.in_y);
    assign in_z        = num_t'(io.in_z);

    // Stage p0: quadrant pre-rotation so the micro-rotations only see +/-pi/2.
    always_comb begin
        pre_x_d = in_x;
        pre_y_d = in_y;
        pre_z_d = in_z;
        if (!io.in_mode) begin
            if (in_z > HALF_PI_C) begin
                pre_x_d = -in_y;
                pre_y_d = in_x;
                pre_z_d = in_z - HALF_PI_C;
            end else if (in_z < -HALF_PI_C) begin
                pre_x_d = in_y;
                pre_y_d = -in_x;
                pre_z_d = in_z + HALF_PI_C;
            end
        end else begin
            pre_z_d = '0;
            if (in_x[NUM_WIDTH-1] && !in_y[NUM_WIDTH-1]) begin
                pre_x_d = in_y;
                pre_y_d = -in_x;
                pre_z_d = HALF_PI_C;
            end else if (in_x[NUM_WIDTH-1]) begin
                pre_x_d = -in_y;
                pre_y_d = in_x;
                pre_z_d = -HALF_PI_C;
            end
        end
    end

    // Stages 1..STAGE_CNT: micro-rotation i shifts by i.
    for (genvar i = 0; i < STAGE_CNT; i++) begin : g_stage
        localparam num_t ATAN_I = to_fixed(atan_pow2(i));
        logic d_pos;
        num_t xs, ys;
        assign d_pos      = mode_q[i] ? y_q[i][NUM_WIDTH-1] : !z_q[i][NUM_WIDTH-1];
        assign xs         = x_q[i] >>> i;
        assign ys         = y_q[i] >>> i;
        assign x_d[i + 1] = d_pos ? x_q[i] - ys : x_q[i] + ys;
        assign y_d[i + 1] = d_pos ? y_q[i] + xs : y_q[i] - xs;
        assign z_d[i + 1] = d_pos ? z_q[i] - ATAN_I : z_q[i] + ATAN_I;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            x_q[0]   <= pre_x_d;
            y_q[0]   <= pre_y_d;
            z_q[0]   <= pre_z_d;
            tag_q[0] <= io.in_tag;
            for (int i = 1; i <= STAGE_CNT; i++) begin
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
                z_q[i]   <= z_d[i];
                tag_q[i] <= tag_q[i - 1];
            end
        end
    end

    // Output register stage; clears on reset so nothing stale is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            mode_q     <= '0;
            out_vld_q  <= 1'b0;
            out_mode_q <= 1'b0;
            out_tag_q  <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_z_q    <= '0;
        end else if (en) begin
            vld_q      <= {vld_q[STAGE_CNT-1:0], io.in_valid};
            mode_q     <= {mode_q[STAGE_CNT-1:0], io.in_mode};
            out_vld_q  <= vld_q[STAGE_CNT];
            out_mode_q <= mode_q[STAGE_CNT];
            out_tag_q  <= tag_q[STAGE_CNT];
            out_x_q    <= x_q[STAGE_CNT];
            out_y_q    <= y_q[STAGE_CNT];
            out_z_q    <= z_q[STAGE_CNT];
        end
    end

    assign io.out_valid = out_vld_q;
    assign io.out_mode  = out_mode_q;
    assign io.out_tag   = out_tag_q;
    assign io.out_x     = out_x_q;
    assign io.out_y     = out_y_q;
    assign io.out_z     = out_z_q;
endmodule

// File: tb/tb_cordic_pipe_multi.sv
// Scoreboard bench for cordic_pipe_multi: directed vectors with hand-computed
// results, mid-stream reset, and a backpressured mixed-mode stream.
module tb_cordic_pipe_multi;
    localparam int NW   = 24;
    localparam int TW   = 4;
    localparam int LAT  = 22;
    localparam int NVEC = 14;

    typedef logic signed [NW-1:0] num_t;

    typedef struct {
        logic mode;
        num_t x, y, z;
        num_t ex, ey, ez;
        int   tol;
        bit   chk_z;
    } vec_t;

    typedef struct {
        logic          mode;
        logic [TW-1:0] tag;
        num_t          ex, ey, ez;
        int            tol;
        bit            chk_z;
        int            cyc;
        bit            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_pipe_multi_if #(.NUM_WIDTH(NW), .TAG_WIDTH(TW)) bus ();

    cordic_pipe_multi #(
        .NUM_WIDTH(NW),
        .FRAC_BITS(20),
        .STAGE_CNT(20),
        .TAG_WIDTH(TW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    bit   bp_en = 1'b0;
    int   hold_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic m, input num_t x, y, z, ex, ey, ez,
                                input int tol, input bit cz);
        vec_t v;
        v.mode = m; v.x = x; v.y = y; v.z = z;
        v.ex = ex; v.ey = ey; v.ez = ez; v.tol = tol; v.chk_z = cz;
        return v;
    endfunction

    // Scale: 1.0 = 0x100000, G = 1.646760 (20 stages). Modes alternate rot/vec.
    function automatic vec_t vec(input int i);
        case (i)
            0:  return mk(1'b0, 24'sh09B74F, '0, '0, 24'sh100000, '0, '0, 32, 1'b1);
            1:  return mk(1'b1, -24'sh080000, -24'sh080000, '0, 24'sh12A187, '0, -24'sh25B2F9, 64, 1'b1);
            2:  return mk(1'b0, 24'sh09B74F, '0, 24'sh1921FB, '0, 24'sh100000, '0, 32, 1'b1);
            3:  return mk(1'b1, 24'sh100000, '0, '0, 24'sh1A5921, '0, '0, 64, 1'b1);
            4:  return mk(1'b0, 24'sh09B74F, '0, -24'sh3243F6, -24'sh100000, '0, '0, 32, 1'b1);
            5:  return mk(1'b1, -24'sh100000, '0, '0, 24'sh1A5921, '0, 24'sh3243F7, 64, 1'b1);
            6:  return mk(1'b0, 24'sh09B74F, '0, 24'sh25B2F9, -24'sh0B504F, 24'sh0B504F, '0, 32, 1'b1);
            7:  return mk(1'b1, '0, 24'sh100000, '0, 24'sh1A5921, '0, 24'sh1921FB, 64, 1'b1);
            8:  return mk(1'b0, 24'sh100000, '0, 24'sh10C152, 24'sh0D2C91, 24'sh16D174, '0, 64, 1'b1);
            9:  return mk(1'b1, '0, '0, 24'sh123456, '0, '0, '0, 0, 1'b0);
            10: return mk(1'b0, 24'sh09B74F, '0, -24'sh1921FB, '0, -24'sh100000, '0, 32, 1'b1);
            11: return mk(1'b1, 24'sh080000, -24'sh080000, '0, 24'sh12A187, '0, -24'sh0C90FE, 64, 1'b1);
            12: return mk(1'b0, '0, 24'sh080000, 24'sh3243F6, '0, -24'sh0D2C91, '0, 64, 1'b1);
            default: return mk(1'b1, -24'sh080000, 24'sh080000, '0, 24'sh12A187, '0, 24'sh25B2F9, 64, 1'b1);
        endcase
    endfunction

    function automatic bit near(input num_t a, input num_t e, input int tol);
        int d;
        d = int'(a) - int'(e);
        return (d <= tol) && (d >= -tol);
    endfunction

    task automatic check(input string name, input int act, input int req, input bit ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic send(input int idx, input logic [TW-1:0] tag, input bit lat);
        vec_t v;
        exp_t e;
        int   guard;
        v     = vec(idx);
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode  = v.mode;
        bus.in_x     = v.x;
        bus.in_y     = v.y;
        bus.in_z     = v.z;
        bus.in_tag   = tag;
        #2;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", int'(bus.in_ready), 1, 1'b0);
        end else begin
            e.mode = v.mode; e.tag = tag; e.ex = v.ex; e.ey = v.ey; e.ez = v.ez;
            e.tol = v.tol; e.chk_z = v.chk_z; e.cyc = cyc; e.lat = lat;
            sb.push_back(e);
            @(posedge clk);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", sb.size(), 0, sb.size() == 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : bp_drv
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!bp_en)
                bus.out_ready = 1'b1;
            else if (cyc >= hold_start && cyc < hold_start + 30)
                bus.out_ready = 1'b0;
            else
                bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : monitor
        exp_t          e;
        num_t          hx, hy, hz;
        logic          hm;
        logic [TW-1:0] ht;
        bit            held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            check("in_ready_rule", int'(bus.in_ready), int'(bus.out_ready | ~bus.out_valid),
                  bus.in_ready == (bus.out_ready | ~bus.out_valid));
            if (held)
                check("stall_hold", int'(bus.out_x), int'(hx),
                      bus.out_valid && bus.out_x == hx && bus.out_y == hy &&
                      bus.out_z == hz && bus.out_mode == hm && bus.out_tag == ht);
            held = 1'b0;
            if (bus.out_valid) begin
                if (!bus.out_ready) begin
                    held = 1'b1;
                    hx = bus.out_x; hy = bus.out_y; hz = bus.out_z;
                    hm = bus.out_mode; ht = bus.out_tag;
                end else if (sb.size() == 0) begin
                    check("unexpected_out", int'(bus.out_tag), -1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("out_tag", int'(bus.out_tag), int'(e.tag), bus.out_tag == e.tag);
                    check("out_mode", int'(bus.out_mode), int'(e.mode), bus.out_mode == e.mode);
                    check("out_x", int'(bus.out_x), int'(e.ex), near(bus.out_x, e.ex, e.tol));
                    check("out_y", int'(bus.out_y), int'(e.ey), near(bus.out_y, e.ey, e.tol));
                    if (e.chk_z)
                        check("out_z", int'(bus.out_z), int'(e.ez), near(bus.out_z, e.ez, 32));
                    if (e.lat)
                        check("latency", cyc - e.cyc, LAT, (cyc - e.cyc) == LAT);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mode  = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_z     = '0;
        bus.in_tag   = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0, bus.out_valid == 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_in_ready", int'(bus.in_ready), 1, bus.in_ready == 1'b1);

        send(0, 4'h5, 1'b1);
        drain();

        for (int i = 0; i < NVEC; i++) send(i, 4'(i), 1'b0);
        drain();

        for (int i = 0; i < NVEC; i++) send(i, 4'(i), 1'b0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", int'(bus.out_valid), 0, bus.out_valid == 1'b0);
        check("rst_mid_x", int'(bus.out_x), 0, bus.out_x == '0);
        check("rst_mid_y", int'(bus.out_y), 0, bus.out_y == '0);
        check("rst_mid_z", int'(bus.out_z), 0, bus.out_z == '0);
        check("rst_mid_mode", int'(bus.out_mode), 0, bus.out_mode == 1'b0);
        check("rst_mid_tag", int'(bus.out_tag), 0, bus.out_tag == '0);
        sb.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rel_in_ready", int'(bus.in_ready), 1, bus.in_ready == 1'b1);
        repeat (40) @(negedge clk);
        send(2, 4'hA, 1'b1);
        drain();

        hold_start = cyc + 26;
        bp_en      = 1'b1;
        for (int i = 0; i < 40; i++) send(i % NVEC, 4'(i), 1'b0);
        drain();
        bp_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
